// File: rtl/mul_rs_sched_if.sv
// Station, execution-unit and CDB signals of the multiply/divide issue scheduler.
// master = scheduler side, slave = stations / unit / CDB arbiter side.
interface mul_rs_sched_if;
    logic [2:0]  rs_busy;
    logic [2:0]  rs_rdy1;
    logic [2:0]  rs_rdy2;
    logic [11:0] rs_func;
    logic [23:0] rs_op1;
    logic [23:0] rs_op2;
    logic [8:0]  rs_rob;
    logic [11:0] rs_rd;
    logic [15:0] ex_result;
    logic        cdb_gnt;

    logic        ex_start;
    logic [3:0]  ex_func;
    logic [7:0]  ex_op1;
    logic [7:0]  ex_op2;
    logic        sched_busy;
    logic        cdb_req;
    logic [15:0] cdb_data;
    logic [2:0]  cdb_rob;
    logic [3:0]  cdb_rd;
    logic [2:0]  rs_clr;

    modport master (
        input  rs_busy, rs_rdy1, rs_rdy2, rs_func, rs_op1, rs_op2, rs_rob, rs_rd,
        input  ex_result, cdb_gnt,
        output ex_start, ex_func, ex_op1, ex_op2, sched_busy,
        output cdb_req, cdb_data, cdb_rob, cdb_rd, rs_clr
    );

    modport slave (
        output rs_busy, rs_rdy1, rs_rdy2, rs_func, rs_op1, rs_op2, rs_rob, rs_rd,
        output ex_result, cdb_gnt,
        input  ex_start, ex_func, ex_op1, ex_op2, sched_busy,
        input  cdb_req, cdb_data, cdb_rob, cdb_rd, rs_clr
    );
endinterface

// File: rtl/mul_rs_sched.sv
// Round-robin issue scheduler for the shared MUL/DIV unit: issue, latency timing, CDB writeback.
// Optional feature: define MUL_RS_SCHED_DIV_EN to make func 4'b0011 (divide) eligible with DIV_LAT.
module mul_rs_sched #(
    parameter int unsigned MUL_LAT = 6,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic           clk1,
    input  logic           rst,
    mul_rs_sched_if.master bus
);

    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] MUL_CNT  = MUL_LAT[3:0];
`ifdef MUL_RS_SCHED_DIV_EN
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];
`endif

    if (MUL_LAT < 1 || MUL_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_lat
        $error("mul_rs_sched: MUL_LAT and DIV_LAT must lie in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ex_start_q, ex_start_d;
    logic [3:0]  ex_func_q, ex_func_d;
    logic [7:0]  ex_op1_q, ex_op1_d;
    logic [7:0]  ex_op2_q, ex_op2_d;
    logic [15:0] cdb_data_q, cdb_data_d;
    logic [2:0]  cdb_rob_q, cdb_rob_d;
    logic [3:0]  cdb_rd_q, cdb_rd_d;
    logic [2:0]  rs_clr_c;

    logic [3:0]  st_func [3];
    logic [7:0]  st_op1  [3];
    logic [7:0]  st_op2  [3];
    logic [2:0]  st_rob  [3];
    logic [3:0]  st_rd   [3];
    logic [2:0]  elig;
    logic        any_elig;
    logic [1:0]  cand0, cand1, cand2;
    logic [1:0]  sel;

    function automatic logic func_ok(input logic [3:0] f);
`ifdef MUL_RS_SCHED_DIV_EN
        return (f == FUNC_MUL) || (f == FUNC_DIV);
`else
        return f == FUNC_MUL;
`endif
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_func[i] = bus.rs_func[4*i +: 4];
            st_op1[i]  = bus.rs_op1[8*i +: 8];
            st_op2[i]  = bus.rs_op2[8*i +: 8];
            st_rob[i]  = bus.rs_rob[3*i +: 3];
            st_rd[i]   = bus.rs_rd[4*i +: 4];
            elig[i]    = bus.rs_busy[i] & bus.rs_rdy1[i] & bus.rs_rdy2[i] & func_ok(st_func[i]);
        end
    end

    // Search order starts at rr and wraps, so the last-served station has lowest priority.
    always_comb begin
        cand0    = rr_q;
        cand1    = rr_next(cand0);
        cand2    = rr_next(cand1);
        any_elig = |elig;
        if (elig[cand0]) begin
            sel = cand0;
        end else if (elig[cand1]) begin
            sel = cand1;
        end else begin
            sel = cand2;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        ex_start_d = 1'b0;
        ex_func_d  = ex_func_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        cdb_data_d = cdb_data_q;
        cdb_rob_d  = cdb_rob_q;
        cdb_rd_d   = cdb_rd_q;
        rs_clr_c   = 3'b000;

        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    k_d        = sel;
                    rr_d       = rr_next(sel);
                    ex_start_d = 1'b1;
                    ex_func_d  = st_func[sel];
                    ex_op1_d   = st_op1[sel];
                    ex_op2_d   = st_op2[sel];
                    cdb_rob_d  = st_rob[sel];
                    cdb_rd_d   = st_rd[sel];
`ifdef MUL_RS_SCHED_DIV_EN
                    cnt_d      = (st_func[sel] == FUNC_DIV) ? DIV_CNT : MUL_CNT;
`else
                    cnt_d      = MUL_CNT;
`endif
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // The unit is combinational from the held operands, so its output is final here.
                if (cnt_q == 4'd1) begin
                    cdb_data_d = bus.ex_result;
                    cnt_d      = 4'd0;
                    state_d    = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                if (bus.cdb_gnt) begin
                    rs_clr_c = 3'b001 << k_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 2'd0;
            k_q        <= 2'd0;
            cnt_q      <= 4'd0;
            ex_start_q <= 1'b0;
            ex_func_q  <= 4'd0;
            ex_op1_q   <= 8'd0;
            ex_op2_q   <= 8'd0;
            cdb_data_q <= 16'd0;
            cdb_rob_q  <= 3'd0;
            cdb_rd_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            ex_start_q <= ex_start_d;
            ex_func_q  <= ex_func_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            cdb_data_q <= cdb_data_d;
            cdb_rob_q  <= cdb_rob_d;
            cdb_rd_q   <= cdb_rd_d;
        end
    end

    assign bus.ex_start   = ex_start_q;
    assign bus.ex_func    = ex_func_q;
    assign bus.ex_op1     = ex_op1_q;
    assign bus.ex_op2     = ex_op2_q;
    assign bus.sched_busy = (state_q != IDLE);
    assign bus.cdb_req    = (state_q == WB);
    assign bus.cdb_data   = cdb_data_q;
    assign bus.cdb_rob    = cdb_rob_q;
    assign bus.cdb_rd     = cdb_rd_q;
    assign bus.rs_clr     = rs_clr_c;

endmodule

// File: tb/tb_mul_rs_sched.sv
// Scoreboard bench for mul_rs_sched: directed station loads, expected CDB results queued at issue
// and checked by a negedge monitor on every cdb_req/cdb_gnt handshake.
module tb_mul_rs_sched;

    localparam logic [3:0] F_MUL = 4'b0010;
    localparam logic [3:0] F_DIV = 4'b0011;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [2:0]  clr;
    } cdb_exp_t;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    mul_rs_sched_if bus ();

    mul_rs_sched #(.MUL_LAT(6), .DIV_LAT(8)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    // Behavioural unit: product for MUL, quotient for DIV (all ones on divide by zero).
    assign bus.ex_result = (bus.ex_func == F_DIV)
                         ? ((bus.ex_op2 == 8'd0) ? 16'hFFFF : {8'd0, bus.ex_op1 / bus.ex_op2})
                         : ({8'd0, bus.ex_op1} * {8'd0, bus.ex_op2});

    cdb_exp_t   exp_q[$];
    int         start_cyc_q[$];
    logic [7:0] start_op_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         hs_count = 0;
    int         hs_cyc = -1;
    int         clr_count = 0;
    logic [2:0] clr_pending = 3'b000;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic cdb_exp_t mkExp(input logic [15:0] d, input logic [2:0] r,
                                       input logic [3:0] rd, input logic [2:0] c);
        cdb_exp_t e;
        e.data = d;
        e.rob  = r;
        e.rd   = rd;
        e.clr  = c;
        return e;
    endfunction

    // Monitor: logs issues, tracks free strobes and scores every CDB handshake.
    always @(negedge clk1) begin
        if (bus.ex_start) begin
            start_cyc_q.push_back(cyc);
            start_op_q.push_back(bus.ex_op1);
        end
        if (bus.rs_clr != 3'b000) begin
            clr_count++;
            clr_pending = clr_pending | bus.rs_clr;
            if (!(bus.cdb_req && bus.cdb_gnt))
                checkOutput("clr_outside_grant", {29'd0, bus.rs_clr}, 32'd0);
        end
        if (bus.cdb_req && bus.cdb_gnt) begin
            hs_count++;
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                checkOutput("cdb_unexpected_qsize", exp_q.size(), 32'd1);
            end else begin
                cdb_exp_t e;
                e = exp_q.pop_front();
                checkOutput("cdb_data", bus.cdb_data, e.data);
                checkOutput("cdb_rob", bus.cdb_rob, e.rob);
                checkOutput("cdb_rd", bus.cdb_rd, e.rd);
                checkOutput("rs_clr", bus.rs_clr, e.clr);
            end
        end
    end

    // One clock step; stations freed by rs_clr drop their busy bit at the edge.
    task automatic tick();
        @(posedge clk1);
        #1;
        bus.rs_busy = bus.rs_busy & ~clr_pending;
        clr_pending = 3'b000;
    endtask

    task automatic clearStations();
        bus.rs_busy = '0;
        bus.rs_rdy1 = '0;
        bus.rs_rdy2 = '0;
        bus.rs_func = '0;
        bus.rs_op1  = '0;
        bus.rs_op2  = '0;
        bus.rs_rob  = '0;
        bus.rs_rd   = '0;
    endtask

    task automatic applyStimulus(input int i, input logic [3:0] func, input logic [7:0] op1,
                                 input logic [7:0] op2, input logic [2:0] rob, input logic [3:0] rd,
                                 input logic rdy1, input logic rdy2);
        bus.rs_func[4*i +: 4] = func;
        bus.rs_op1[8*i +: 8]  = op1;
        bus.rs_op2[8*i +: 8]  = op2;
        bus.rs_rob[3*i +: 3]  = rob;
        bus.rs_rd[4*i +: 4]   = rd;
        bus.rs_rdy1[i]        = rdy1;
        bus.rs_rdy2[i]        = rdy2;
        bus.rs_busy[i]        = 1'b1;
    endtask

    task automatic checkResetOutputs(input string p);
        checkOutput({p, "_ex_start"}, bus.ex_start, 32'd0);
        checkOutput({p, "_cdb_req"}, bus.cdb_req, 32'd0);
        checkOutput({p, "_sched_busy"}, bus.sched_busy, 32'd0);
        checkOutput({p, "_rs_clr"}, bus.rs_clr, 32'd0);
        checkOutput({p, "_ex_func"}, bus.ex_func, 32'd0);
        checkOutput({p, "_ex_op1"}, bus.ex_op1, 32'd0);
        checkOutput({p, "_ex_op2"}, bus.ex_op2, 32'd0);
        checkOutput({p, "_cdb_data"}, bus.cdb_data, 32'd0);
        checkOutput({p, "_cdb_rob"}, bus.cdb_rob, 32'd0);
        checkOutput({p, "_cdb_rd"}, bus.cdb_rd, 32'd0);
    endtask

    task automatic resetDut(input string p);
        rst = 1'b1;
        clearStations();
        repeat (3) tick();
        checkResetOutputs(p);
        rst = 1'b0;
    endtask

    task automatic waitHandshakes(input int target, input int budget, input string name);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        if (hs_count < target) checkOutput(name, hs_count, target);
    endtask

    task automatic waitStarts(input int target, input int budget, input string name);
        int n = 0;
        while (start_cyc_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (start_cyc_q.size() < target) checkOutput(name, start_cyc_q.size(), target);
    endtask

    task automatic waitReq(input int budget, input string name);
        int n = 0;
        while (!bus.cdb_req && n < budget) begin
            tick();
            n++;
        end
        if (!bus.cdb_req) checkOutput(name, bus.cdb_req, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, sb, hb, cb, s, x;
        bus.cdb_gnt = 1'b0;
        clearStations();

        resetDut("rst0");

        // Single MUL from station 1 with the CDB always granting.
        bus.cdb_gnt = 1'b1;
        applyStimulus(1, F_MUL, 8'd12, 8'd10, 3'd3, 4'd5, 1'b1, 1'b1);
        exp_q.push_back(mkExp(16'd120, 3'd3, 4'd5, 3'b010));
        t0 = cyc; sb = start_cyc_q.size(); hb = hs_count;
        waitHandshakes(hb + 1, 30, "t1_timeout");
        checkOutput("t1_start_cycle", start_cyc_q[sb], t0 + 1);
        checkOutput("t1_cdb_cycle", hs_cyc, t0 + 7);
        checkOutput("t1_busy_low", bus.sched_busy, 32'd0);
        checkOutput("t1_one_start", start_cyc_q.size(), sb + 1);

        // DIV from station 0: issues only when the divide feature is built in.
        applyStimulus(0, F_DIV, 8'd200, 8'd7, 3'd1, 4'd2, 1'b1, 1'b1);
        t0 = cyc; sb = start_cyc_q.size(); hb = hs_count; cb = clr_count;
`ifdef MUL_RS_SCHED_DIV_EN
        exp_q.push_back(mkExp(16'd28, 3'd1, 4'd2, 3'b001));
        waitHandshakes(hb + 1, 40, "t2_timeout");
        checkOutput("t2_cdb_cycle", hs_cyc, t0 + 9);
        checkOutput("t2_start_cycle", start_cyc_q[sb], t0 + 1);
`else
        repeat (50) tick();
        checkOutput("t2_no_start", start_cyc_q.size(), sb);
        checkOutput("t2_no_clr", clr_count, cb);
        checkOutput("t2_idle", bus.sched_busy, 32'd0);
        checkOutput("t2_still_resident", bus.rs_busy[0], 32'd1);
        bus.rs_busy[0] = 1'b0;
`endif

        // Round robin: three eligible stations, then station 0 refilled after its first clear.
        resetDut("rst1");
        bus.cdb_gnt = 1'b1;
        applyStimulus(0, F_MUL, 8'd3, 8'd4, 3'd0, 4'd1, 1'b1, 1'b1);
        applyStimulus(1, F_MUL, 8'd5, 8'd6, 3'd1, 4'd2, 1'b1, 1'b1);
        applyStimulus(2, F_MUL, 8'd7, 8'd8, 3'd2, 4'd3, 1'b1, 1'b1);
        exp_q.push_back(mkExp(16'd12, 3'd0, 4'd1, 3'b001));
        exp_q.push_back(mkExp(16'd30, 3'd1, 4'd2, 3'b010));
        exp_q.push_back(mkExp(16'd56, 3'd2, 4'd3, 3'b100));
        sb = start_cyc_q.size(); hb = hs_count;
        waitHandshakes(hb + 1, 30, "t3_first_timeout");
        applyStimulus(0, F_MUL, 8'd9, 8'd2, 3'd4, 4'd6, 1'b1, 1'b1);
        exp_q.push_back(mkExp(16'd18, 3'd4, 4'd6, 3'b001));
        waitHandshakes(hb + 4, 80, "t3_all_timeout");
        checkOutput("t3_issue0", start_op_q[sb], 32'd3);
        checkOutput("t3_issue1", start_op_q[sb + 1], 32'd5);
        checkOutput("t3_issue2", start_op_q[sb + 2], 32'd7);
        checkOutput("t3_issue3", start_op_q[sb + 3], 32'd9);

        // Backpressure: grant withheld for 10 WB cycles while another station waits.
        bus.cdb_gnt = 1'b0;
        applyStimulus(2, F_MUL, 8'd15, 8'd17, 3'd5, 4'd7, 1'b1, 1'b1);
        exp_q.push_back(mkExp(16'd255, 3'd5, 4'd7, 3'b100));
        waitReq(20, "t4_req_timeout");
        applyStimulus(0, F_MUL, 8'd2, 8'd3, 3'd6, 4'd8, 1'b1, 1'b1);
        exp_q.push_back(mkExp(16'd6, 3'd6, 4'd8, 3'b001));
        sb = start_cyc_q.size(); cb = clr_count; hb = hs_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t4_hold_req", bus.cdb_req, 32'd1);
            checkOutput("t4_hold_data", bus.cdb_data, 32'd255);
            checkOutput("t4_hold_rob", bus.cdb_rob, 32'd5);
            checkOutput("t4_hold_rd", bus.cdb_rd, 32'd7);
            checkOutput("t4_hold_clr", bus.rs_clr, 32'd0);
        end
        checkOutput("t4_no_new_start", start_cyc_q.size(), sb);
        bus.cdb_gnt = 1'b1;
        x = cyc;
        tick();
        bus.cdb_gnt = 1'b0;
        repeat (3) tick();
        checkOutput("t4_one_clr", clr_count, cb + 1);
        checkOutput("t4_issue_after_gnt", start_cyc_q[sb], x + 2);
        bus.cdb_gnt = 1'b1;
        waitHandshakes(hb + 2, 30, "t4_drain_timeout");

        // Not ready: station 2 waits on operand 2.
        applyStimulus(2, F_MUL, 8'd4, 8'd5, 3'd7, 4'd9, 1'b1, 1'b0);
        sb = start_cyc_q.size(); hb = hs_count;
        repeat (10) tick();
        checkOutput("t5_no_start", start_cyc_q.size(), sb);
        checkOutput("t5_idle", bus.sched_busy, 32'd0);
        bus.rs_rdy2[2] = 1'b1;
        t0 = cyc;
        exp_q.push_back(mkExp(16'd20, 3'd7, 4'd9, 3'b100));
        waitHandshakes(hb + 1, 30, "t5_timeout");
        checkOutput("t5_start_cycle", start_cyc_q[sb], t0 + 1);

        // Reset during the third EXEC cycle drops the instruction; the station re-issues.
        applyStimulus(1, F_MUL, 8'd6, 8'd7, 3'd2, 4'd3, 1'b1, 1'b1);
        sb = start_cyc_q.size(); hb = hs_count; cb = clr_count;
        waitStarts(sb + 1, 20, "t6_start_timeout");
        s = (start_cyc_q.size() > sb) ? start_cyc_q[sb] : cyc;
        while (cyc < s + 2) tick();
        rst = 1'b1;
        tick();
        checkResetOutputs("t6_rst");
        checkOutput("t6_no_cdb", hs_count, hb);
        checkOutput("t6_no_clr", clr_count, cb);
        rst = 1'b0;
        t0 = cyc;
        exp_q.push_back(mkExp(16'd42, 3'd2, 4'd3, 3'b010));
        waitHandshakes(hb + 1, 30, "t6_reissue_timeout");
        checkOutput("t6_reissue_cycle", start_cyc_q[sb + 1], t0 + 1);

        repeat (3) tick();
        checkOutput("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_rs_sched.md
# mul_rs_sched

Issue scheduler and sequencer for the shared multiply/divide execution unit in the Tomasulo core. It arbitrates round-robin among the three multiply reservation stations, issues one ready entry at a time, and times the unit's fixed MUL/DIV latency. It then posts the result on the common data bus (CDB) under a req/gnt handshake and frees the originating station. The unit it drives is combinational from the operands this block presents.

## Interface
- MUL_LAT, 6: cycles from `ex_start` to result capture for func 4'b0010; legal 1..15
- DIV_LAT, 8: same for func 4'b0011; legal 1..15
- clk1  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- rs_busy  in  3  station i holds an instruction
- rs_rdy1, rs_rdy2  in  3 each  station i operand 1/2 valid
- rs_func  in  12  station i func at [4i+3:4i]
- rs_op1, rs_op2  in  24 each  station i operand at [8i+7:8i]
- rs_rob  in  9  station i ROB index at [3i+2:3i]
- rs_rd  in  12  station i destination register at [4i+3:4i]
- ex_result  in  16  unit output
- cdb_gnt  in  1  CDB grant
- ex_start  out  1  one-cycle issue pulse to unit
- ex_func  out  4  func to unit
- ex_op1, ex_op2  out  8 each  operands to unit
- sched_busy  out  1  state != IDLE
- cdb_req  out  1  result pending on CDB
- cdb_data  out  16  result
- cdb_rob  out  3  ROB tag
- cdb_rd  out  4  destination register, used by stations for wakeup
- rs_clr  out  3  one-hot station free strobe

## Operation
- Eligible(i) = rs_busy[i] & rs_rdy1[i] & rs_rdy2[i] & func(i) ∈ {4'b0010, 4'b0011}. Any other func is never eligible.
- Round-robin pointer rr (0..2, reset 0): search order is rr, rr+1, rr+2 mod 3. On issue from station k, rr ← (k+1) mod 3.
- FSM IDLE → EXEC → WB → IDLE.
  - IDLE: if any station is eligible, latch k, func, op1, op2, rob and rd; load cnt ← MUL_LAT or DIV_LAT; assert ex_start for one cycle; go to EXEC. Otherwise stay.
  - EXEC: cnt decrements each cycle. At the edge where cnt==1, capture ex_result → cdb_data and go to WB.
  - WB: cdb_req=1, with cdb_data/cdb_rob/cdb_rd held stable. In a cycle with cdb_gnt=1, rs_clr[k]=1 combinationally that cycle, and the next state is IDLE with cdb_req=0.
- ex_func, ex_op1 and ex_op2 hold their latched values from issue until the next issue.
- Station inputs for k are ignored after latching, so a station change mid-execution has no effect.
- Divide-by-zero handling belongs to the unit; the block forwards ex_result unchanged.

## Timing
- Reset values: ex_start, cdb_req, sched_busy, rs_clr = 0; ex_func, ex_op1, ex_op2, cdb_data, cdb_rob, cdb_rd = 0; rr = 0; state = IDLE; cnt = 0.
- Station eligible in cycle T → ex_start high in T+1 → unit result sampled at the end of T+LAT → cdb_req high from T+LAT+1.
- Grant in the first WB cycle G → rs_clr pulse in G → IDLE in G+1 → earliest next ex_start in G+2.
- cdb_gnt while not in WB is ignored. If gnt is withheld, WB holds indefinitely with a stable payload.
- rst in any state takes effect at the next edge. An in-flight instruction is dropped, no rs_clr is issued, and all outputs return to reset values.
- Eligibility is sampled only in IDLE. Multiple eligible stations in the same cycle are resolved by rr.

## Configuration
- MUL_RS_SCHED_DIV_EN defined: func 4'b0011 is eligible and uses DIV_LAT.
- MUL_RS_SCHED_DIV_EN undefined: func 4'b0011 is never eligible, so such stations stay resident and are never cleared. DIV_LAT is unused and the DIV latency path is not synthesized.

## Test plan
- Single MUL, with the bench unit returning op1*op2: station 1 has op1=12, op2=10, rob=3, rd=5 and becomes eligible in cycle 0, with cdb_gnt tied 1. Required: ex_start in cycle 1; cdb_req in cycle 7 with cdb_data=120, cdb_rob=3, cdb_rd=5; rs_clr=3'b010 in cycle 7; sched_busy low in cycle 8.
- DIV (macro defined): op1=200, op2=7 in station 0. Required: cdb_req 9 cycles after eligibility with cdb_data=28. With the macro undefined, the same stimulus must produce no ex_start for 50 cycles.
- Round-robin: all three stations eligible at once, each granted immediately. Required: issue order 0, 1, 2, and after station 0 is refilled, the next issue is still 0 only once rr has wrapped.
- Backpressure: cdb_gnt held 0 for 10 cycles in WB. Required: cdb_req and the payload stay stable, rs_clr stays 0, and no new ex_start occurs. After gnt: exactly one rs_clr pulse.
- Not ready: station 2 has rdy2=0 → no issue. Raising rdy2 in cycle N gives ex_start in N+1.
- Mid-op reset: rst asserted in the 3rd EXEC cycle. Required: all outputs at reset values the next cycle, no cdb_req and no rs_clr. After rst is released, the still-busy station re-issues.
